// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the 8x16 register file and the command host that
// drives its access port.
//   REGFILE_ADDR_W / REGFILE_DATA_W : geometry of the register file
//   state_t                         : host FSM states (IDLE, WR, RD, CAP, RSP)
//   cmd_t                           : one host command (write flag, address, data)
package regfile_pkg;

    localparam int REGFILE_ADDR_W = 3;
    localparam int REGFILE_DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        CAP  = 3'd3,
        RSP  = 3'd4
    } state_t;

    typedef struct packed {
        logic                      write;
        logic [REGFILE_ADDR_W-1:0] addr;
        logic [REGFILE_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/regfile_host.sv
// regfile_host
// Command-driven host for the register file. It takes one read or write
// command at a time, strobes the register file, and returns a response.
// Only one transaction is ever outstanding.
//
// Optional feature: define REGFILE_HOST_READBACK_EN to follow every write
// with a verify read of the same address. rsp_err then flags a readback
// that differs from the written data. Without it, rsp_err is tied to 0.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while IDLE)
//   cmd_write/addr/wdata command payload
//   rsp_valid/rsp_ready response handshake
//   rsp_rdata, rsp_err  response payload, held stable while in RSP
//   WrEn, RdEn          register-file strobes (registered, never both high)
//   Address, WrData     register-file address and write data (registered)
//   RdData              register-file read data, valid the cycle after RdEn
module regfile_host
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    input  logic [DATA_W-1:0] RdData
);

    state_t state;
    state_t state_nxt;
    logic   accept;

    // Next-state decode. A command is accepted only in IDLE. Reads go through
    // RD then CAP because the register file returns data one cycle after RdEn.
    always_comb begin
        state_nxt = state;
        cmd_ready = (state == IDLE);
        accept    = cmd_valid && (state == IDLE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = cmd_write ? WR : RD;
                end
            end
`ifdef REGFILE_HOST_READBACK_EN
            WR:      state_nxt = RD;
`else
            WR:      state_nxt = RSP;
`endif
            RD:      state_nxt = CAP;
            CAP:     state_nxt = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and strobe outputs. The strobes are computed from the
    // next state so they are registered yet coincide exactly with WR/RD.
    // RSP is likewise mirrored into rsp_valid.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            WrEn      <= (state_nxt == WR);
            RdEn      <= (state_nxt == RD);
            rsp_valid <= (state_nxt == RSP);
        end
    end

    // The command latch is Address/WrData themselves. They are loaded on the
    // accept edge so they are already valid in the WR/RD cycle, and they hold
    // until the next accepted command.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Address <= '0;
            WrData  <= '0;
        end else if (accept) begin
            Address <= cmd_addr;
            WrData  <= cmd_wdata;
        end
    end

    // Response data is cleared when a command is accepted, so a plain write
    // answers with zero. It is loaded only in CAP and holds through RSP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_rdata <= '0;
        end else if (accept) begin
            rsp_rdata <= '0;
        end else if (state == CAP) begin
            rsp_rdata <= RdData;
        end
    end

`ifdef REGFILE_HOST_READBACK_EN
    logic wr_q;

    // Readback compare. CAP is reached after either a read or a verify read.
    // Only the verify read of a write compares the returned word with the
    // data just written (still held in WrData).
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_q    <= 1'b0;
            rsp_err <= 1'b0;
        end else if (accept) begin
            wr_q    <= cmd_write;
            rsp_err <= 1'b0;
        end else if (state == CAP) begin
            rsp_err <= wr_q && (RdData != WrData);
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_host.sv
// tb_regfile_host
// Bench for regfile_host. It attaches a small behavioural register file to
// the host's access port. It also keeps its own reference copy of the
// register contents, updated only from the commands it issues. Expected
// response data, error flags and latencies come from that copy and the
// documented cycle timing.
module tb_regfile_host;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [2:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        WrEn;
    logic        RdEn;
    logic [2:0]  Address;
    logic [15:0] WrData;
    logic [15:0] RdData;

    logic [15:0] rfMem [8];
    logic [15:0] refMem [8];
    logic        preloadEn;
    logic [2:0]  preloadAddr;
    logic [15:0] preloadData;
    logic        corruptRead;

    int errors = 0;
    int checks = 0;

`ifdef REGFILE_HOST_READBACK_EN
    localparam int WR_LAT = 4;
    localparam bit READBACK = 1'b1;
`else
    localparam int WR_LAT = 2;
    localparam bit READBACK = 1'b0;
`endif
    localparam int RD_LAT = 3;

    regfile_host dut (
        .CLK       (CLK),
        .RST       (RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .WrEn      (WrEn),
        .RdEn      (RdEn),
        .Address   (Address),
        .WrData    (WrData),
        .RdData    (RdData)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 CLK = ~CLK;

    // Behavioural register file: write on WrEn, registered read on RdEn.
    // corruptRead forces the returned word to zero to provoke a readback
    // mismatch. preloadEn lets the bench seed contents.
    always @(posedge CLK) begin
        if (preloadEn) begin
            rfMem[preloadAddr] <= preloadData;
        end else if (WrEn) begin
            rfMem[Address] <= WrData;
        end
        if (RdEn) begin
            RdData <= corruptRead ? 16'h0000 : rfMem[Address];
        end
    end

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Seed one register in both the attached model and the reference copy.
    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        preloadEn   = 1'b1;
        preloadAddr = a;
        preloadData = d;
        tick();
        preloadEn   = 1'b0;
        refMem[a]   = d;
    endtask

    // One complete transaction. It checks the strobes in the cycle after
    // acceptance, the response latency and payload, and stability while
    // rsp_ready is held low for 'delay' extra cycles. It optionally offers
    // a second command during the hold, which must be ignored. Finally it
    // checks the return to IDLE after the handshake.
    task automatic applyStimulus(input logic wr, input logic [2:0] a, input logic [15:0] d,
                                 input int delay, input logic offerExtra);
        logic [15:0] expData;
        logic        expErr;
        int          expLat;
        int          cyc;

        if (wr) begin
            expData = READBACK ? (corruptRead ? 16'h0000 : d) : 16'h0000;
            expErr  = READBACK && corruptRead && (d != 16'h0000);
            expLat  = WR_LAT;
        end else begin
            expData = refMem[a];
            expErr  = 1'b0;
            expLat  = RD_LAT;
        end

        checkOutput("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = (delay == 0);
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = $urandom;

        checkOutput("n1_wren", WrEn, wr);
        checkOutput("n1_rden", RdEn, !wr);
        checkOutput("n1_address", Address, a);
        if (wr) checkOutput("n1_wrdata", WrData, d);
        checkOutput("n1_cmd_ready", cmd_ready, 0);
        checkOutput("n1_rsp_valid", rsp_valid, 0);

        cyc = 1;
        while (!rsp_valid && cyc < 12) begin
            tick();
            cyc++;
            checkOutput("strobe_exclusive", WrEn & RdEn, 0);
            if (cyc == 2) begin
                checkOutput("n2_wren", WrEn, 0);
                checkOutput("n2_rden", RdEn, wr && READBACK);
            end
        end
        checkOutput("rsp_latency", cyc, expLat);
        checkOutput("rsp_rdata", rsp_rdata, expData);
        checkOutput("rsp_err", rsp_err, expErr);

        if (wr) refMem[a] = d;

        if (offerExtra) begin
            cmd_valid = 1'b1;
            cmd_write = $urandom_range(0, 1);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_rdata", rsp_rdata, expData);
            checkOutput("hold_rsp_err", rsp_err, expErr);
            checkOutput("hold_cmd_ready", cmd_ready, 0);
            checkOutput("hold_no_strobe", {WrEn, RdEn}, 0);
        end

        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", rsp_valid, 0);
        checkOutput("post_cmd_ready", cmd_ready, 1);
        checkOutput("post_no_strobe", {WrEn, RdEn}, 0);
    endtask

    // Reset asserted while the host sits in CAP: the read must vanish.
    task automatic resetMidRead(input logic [2:0] a);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checkOutput("midrst_rd_strobe", RdEn, 1);
        tick();
        RST = 1'b1;
        tick();
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_rden", RdEn, 0);
        checkOutput("midrst_rsp_rdata", rsp_rdata, 0);
        RST = 1'b0;
        checkOutput("midrst_cmd_ready", cmd_ready, 1);
        tick();
        checkOutput("midrst_no_rsp", rsp_valid, 0);
        checkOutput("midrst_ready_after", cmd_ready, 1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        RST         = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b1;
        cmd_addr    = 3'd5;
        cmd_wdata   = 16'hDEAD;
        rsp_ready   = 1'b0;
        preloadEn   = 1'b0;
        preloadAddr = '0;
        preloadData = '0;
        corruptRead = 1'b0;

        // Reset held two cycles with a command on offer.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_outputs",
                        {16'h0, WrEn, RdEn, rsp_valid, rsp_err, 12'h0},
                        32'h0);
            checkOutput("rst_address", Address, 0);
            checkOutput("rst_wrdata", WrData, 0);
            checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        end
        RST       = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        tick();
        checkOutput("rst_no_accept", {WrEn, RdEn, rsp_valid}, 0);

        for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
        preload(3'd0, 16'h1234);

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 3'd5, 16'hA5C3, 0, 1'b0);
        applyStimulus(1'b0, 3'd5, 16'h0000, 0, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 5, 1'b1);
        applyStimulus(1'b1, 3'd7, 16'hFFFF, 1, 1'b0);
        applyStimulus(1'b1, 3'd0, 16'h0001, 0, 1'b0);
        applyStimulus(1'b0, 3'd7, 16'h0000, 0, 1'b0);
        applyStimulus(1'b0, 3'd0, 16'h0000, 2, 1'b1);

`ifdef REGFILE_HOST_READBACK_EN
        $display("[TB] readback mismatch and match");
        corruptRead = 1'b1;
        applyStimulus(1'b1, 3'd3, 16'hBEEF, 0, 1'b0);
        corruptRead = 1'b0;
        applyStimulus(1'b1, 3'd4, 16'hBEEF, 1, 1'b0);
        applyStimulus(1'b0, 3'd3, 16'h0000, 0, 1'b0);
`endif

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            int dly;
            dly = $urandom_range(0, 3);
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom), 16'($urandom),
                          dly, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during capture");
        resetMidRead(3'd2);
        applyStimulus(1'b0, 3'd2, 16'h0000, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/regfile_host.md
# regfile_host

Command-driven host for the 8x16 register file. Accepts one read or write command at a time over a valid/ready interface and drives the register file's WrEn/RdEn/Address/WrData strobes. It captures the registered RdData and returns a response over a valid/ready interface. It sits between the bus/CPU-side command source and the register file, and is the only agent driving the register file's access port.

## Interface
Parameters:
- DATA_W, 16, data width; must match register-file word width.
- ADDR_W, 3, address width (8 registers).

Ports:
- CLK  in  1  sole clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  host can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_W  read data (or readback data, see Configuration).
- rsp_err  out  1  readback mismatch flag.
- WrEn  out  1  register-file write strobe.
- RdEn  out  1  register-file read strobe.
- Address  out  ADDR_W  register-file address.
- WrData  out  DATA_W  register-file write data.
- RdData  in  DATA_W  register-file read data, valid the cycle after the RdEn cycle.

## Operation
- FSM states are IDLE, WR, RD, CAP and RSP.
- **IDLE:**
  - cmd_ready = 1, and it is decoded combinationally from state == IDLE.
  - On cmd_valid && cmd_ready, latch cmd_write, cmd_addr and cmd_wdata.
  - Go to WR if cmd_write, otherwise go to RD.
- **WR:** WrEn = 1, RdEn = 0, Address/WrData = latched values, held for exactly one cycle. Next state is RSP (or RD, see Configuration).
- **RD:** RdEn = 1, WrEn = 0, Address = latched address, held for one cycle. Next state is CAP.
- **CAP:** Register RdData into rsp_rdata. Next state is RSP.
- **RSP:**
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE.
  - Plain writes return rsp_rdata = 0 and rsp_err = 0.
- WrEn, RdEn, Address and WrData are registered outputs.
- WrEn and RdEn are never both 1. Both are 0 outside WR and RD.
- Only one transaction is outstanding. Commands offered while busy are not accepted, because cmd_ready = 0.
- No address wrap or range check: all 2^ADDR_W addresses are legal.
- The host never reads register contents except through RdEn/RdData.

## Timing
- Command accept edge = cycle N.
- **Write:** WrEn high in cycle N+1; rsp_valid from cycle N+2.
- **Read:** RdEn high in N+1; RdData sampled at the end of N+2 (CAP); rsp_valid from N+3.
- **rsp_ready:**
  - rsp_ready high when rsp_valid first rises ends the response that cycle.
  - rsp_ready low holds RSP indefinitely with rsp_* stable.
- After the rsp handshake in cycle M: IDLE in M+1, and cmd_ready = 1 in M+1. There is no same-cycle response/command overlap.
- **Reset:**
  - RST sampled high forces state = IDLE and clears all registered outputs to 0 on that edge.
  - Cleared outputs: rsp_valid, rsp_rdata, rsp_err, WrEn, RdEn, Address, WrData.
  - cmd_ready = 1 from the cycle after reset.
- **Reset mid-transaction:** the transaction is dropped with no response. A WR-cycle strobe already issued is not undone.

## Configuration
- The macro is REGFILE_HOST_READBACK_EN.
- **Defined:**
  - Every write is followed by a verify read: WR then RD (same address), then CAP, then RSP.
  - CAP captures RdData into rsp_rdata and sets rsp_err = (RdData != latched wdata).
  - Write response arrives at N+4.
- **Undefined:**
  - WR goes directly to RSP.
  - rsp_err is tied to 0.
  - Reads behave identically in both builds.

## Structure
- Shared package regfile_pkg holds:
  - constants REGFILE_ADDR_W = 3 and REGFILE_DATA_W = 16;
  - the FSM state typedef (IDLE, WR, RD, CAP, RSP);
  - a command struct (write, addr, wdata).
- Parameters default from the package constants.
- Single module; no sub-module is warranted. The command latch and response holding registers live inline.

## Test plan
- **Reset:**
  - Stimulus: RST high 2 cycles with cmd_valid = 1.
  - Response: all outputs 0 and no command accepted; cmd_ready = 1 the cycle after RST falls.
- **Write then read (register-file model attached):**
  - Stimulus: write addr 5 data 16'hA5C3, then read addr 5.
  - Response: WrEn pulses one cycle at N+1 with Address = 5. Read response has rsp_rdata = 16'hA5C3 at N+3.
- **Backpressure:**
  - Stimulus: read addr 0 (preloaded 16'h1234) with rsp_ready low for 5 cycles.
  - Response: rsp_valid held, rsp_rdata = 16'h1234 stable, cmd_ready = 0 throughout, and a second offered command is not accepted.
- **Address extremes:**
  - Stimulus: write addr 7 = 16'hFFFF and addr 0 = 16'h0001, then read both.
  - Response: exact values returned; no aliasing.
- **Readback mismatch (REGFILE_HOST_READBACK_EN defined):**
  - Stimulus: model forces RdData = 16'h0000 on the verify read of write 16'hBEEF.
  - Response: rsp_err = 1, rsp_rdata = 16'h0000. A matching case gives rsp_err = 0 and rsp_rdata = 16'hBEEF.
- **Reset mid-read:**
  - Stimulus: RST high during CAP.
  - Response: no rsp_valid, RdEn = 0, and cmd_ready = 1 next cycle after RST falls.
